// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Runs from refclk and supervises the system PLL. It pulses the PLL reset,
//   synchronises and filters the raw locked flag, and releases a clean system
//   reset only after lock has been stable for a programmable time. If lock is
//   lost while running, it re-asserts system reset, counts the event
//   (saturating), and restarts the PLL.
//
//   Optional feature: define PLL_LOCK_TIMEOUT_EN to add a lock-acquisition
//   timeout. With the macro defined, a stay in WAITLOCK/FILTER/HOLD that lasts
//   TIMEOUT_CYCLES sends the FSM back to PLLRST for a fresh PLL reset pulse.
//   Without the macro there is no timeout logic and WAITLOCK waits indefinitely.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES   = 16,
  parameter int unsigned LOCK_FILTER_CYCLES = 1024,
  parameter int unsigned RST_HOLD_CYCLES    = 256,
  parameter int unsigned TIMEOUT_CYCLES     = 500000,
  parameter int unsigned CNT_W              = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             lock_ok,
  output logic             lost_lock,
  output logic [CNT_W-1:0] relock_cnt
);

  // The shared phase counter only ever counts up to (largest phase length - 1).
  localparam int unsigned CTR_MAX_A =
    (RST_PULSE_CYCLES > LOCK_FILTER_CYCLES) ? RST_PULSE_CYCLES : LOCK_FILTER_CYCLES;
  localparam int unsigned CTR_MAX =
    (CTR_MAX_A > RST_HOLD_CYCLES) ? CTR_MAX_A : RST_HOLD_CYCLES;
  localparam int unsigned CTR_W = (CTR_MAX > 1) ? $clog2(CTR_MAX) : 1;

  localparam logic [CTR_W-1:0] PULSE_LAST  = CTR_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CTR_W-1:0] FILTER_LAST = CTR_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CTR_W-1:0] HOLD_LAST   = CTR_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELOCK_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAITLOCK,
    S_FILTER,
    S_HOLD,
    S_RUN
  } state_t;

  state_t           state;
  logic [CTR_W-1:0] cnt;
  logic             lk_meta;
  logic             lk_s;

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
`else
  // TIMEOUT_CYCLES is accepted for interface compatibility but has no effect here.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Two-flop synchroniser bringing the asynchronous PLL lock flag into refclk.
  always_ff @(posedge refclk) begin
    // NOTE: non-blocking assignments make lk_s take the previous lk_meta value,
    // which is what turns these two statements into a two-stage shift register.
    if (rst) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  // Supervisor FSM: state, shared phase counter and all registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= S_PLLRST;
      cnt        <= '0;
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      lock_ok    <= 1'b0;
      lost_lock  <= 1'b0;
      relock_cnt <= '0;
`ifdef PLL_LOCK_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      // lost_lock is a single-cycle strobe unless RUN raises it below.
      lost_lock <= 1'b0;

      case (state)
        // Hold the PLL in reset for the programmed pulse length.
        S_PLLRST: begin
          if (cnt == PULSE_LAST) begin
            state   <= S_WAITLOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CTR_W'(1);
          end
        end

        // Wait for the synchronised lock flag to come up.
        S_WAITLOCK: begin
          if (lk_s) begin
            state <= S_FILTER;
            cnt   <= '0;
          end
        end

        // Require an unbroken run of lock; any drop restarts the wait.
        // A drop on the terminal-count cycle still wins.
        S_FILTER: begin
          if (!lk_s) begin
            state <= S_WAITLOCK;
            cnt   <= '0;
          end else if (cnt == FILTER_LAST) begin
            state <= S_HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CTR_W'(1);
          end
        end

        // Keep downstream logic in reset a little longer after lock qualifies.
        S_HOLD: begin
          if (!lk_s) begin
            state <= S_WAITLOCK;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state   <= S_RUN;
            cnt     <= '0;
            sys_rst <= 1'b0;
            lock_ok <= 1'b1;
          end else begin
            cnt <= cnt + CTR_W'(1);
          end
        end

        // Normal operation: a lock drop resets the system and restarts the PLL.
        S_RUN: begin
          if (!lk_s) begin
            state     <= S_PLLRST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            lock_ok   <= 1'b0;
            lost_lock <= 1'b1;
            if (relock_cnt != RELOCK_MAX) begin
              relock_cnt <= relock_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state   <= S_PLLRST;
          cnt     <= '0;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
          lock_ok <= 1'b0;
        end
      endcase

`ifdef PLL_LOCK_TIMEOUT_EN
      // Lock-acquisition timeout; overrides the per-state decision above so a
      // PLL that never settles gets a fresh reset pulse. relock_cnt is untouched.
      if (state == S_WAITLOCK || state == S_FILTER || state == S_HOLD) begin
        if (tmo_cnt == TMO_LAST) begin
          state   <= S_PLLRST;
          cnt     <= '0;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
          lock_ok <= 1'b0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Directed bench for pll_lock_supervisor with small parameters
//   (pulse 4, filter 8, hold 4, timeout 64, 2-bit relock counter).
//   Edge numbers below count rising edges after rst is released.
//   With lock already present, pll_rst falls on edge 4 and sys_rst on edge 17
//   (4 pulse + 1 wait + 8 filter + 4 hold; synchroniser latency overlaps the pulse).
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       lock_ok;
  logic       lost_lock;
  logic [1:0] relock_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES  (4),
    .LOCK_FILTER_CYCLES(8),
    .RST_HOLD_CYCLES   (4),
    .TIMEOUT_CYCLES    (64),
    .CNT_W             (2)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .lock_ok   (lock_ok),
    .lost_lock (lost_lock),
    .relock_cnt(relock_cnt)
  );

  always #10 refclk = ~refclk;

  // Advance n rising edges, then settle 1 ns so outputs are sampled off the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_cnt;

    // Reset values
    rst        = 1'b1;
    pll_locked = 1'b1;
    tick(3);
    check("rst_pll_rst",    32'(pll_rst),    32'd1);
    check("rst_sys_rst",    32'(sys_rst),    32'd1);
    check("rst_lock_ok",    32'(lock_ok),    32'd0);
    check("rst_lost_lock",  32'(lost_lock),  32'd0);
    check("rst_relock_cnt", 32'(relock_cnt), 32'd0);

    // Clean lock
    rst = 1'b0;
    tick(3);   // edge 3
    check("clean_pulse_e3", 32'(pll_rst), 32'd1);
    tick(1);   // edge 4
    check("clean_pulse_e4", 32'(pll_rst), 32'd0);
    tick(12);  // edge 16
    check("clean_sys_e16",  32'(sys_rst), 32'd1);
    check("clean_ok_e16",   32'(lock_ok), 32'd0);
    tick(1);   // edge 17
    check("clean_sys_e17",  32'(sys_rst), 32'd0);
    check("clean_ok_e17",   32'(lock_ok), 32'd1);
    check("clean_pll_e17",  32'(pll_rst), 32'd0);

    // Loss in RUN, four times; relock counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      exp_cnt = (i < 3) ? 32'(i + 1) : 32'd3;
      pll_locked = 1'b0;
      tick(2);
      check("loss_no_pulse_yet", 32'(lost_lock), 32'd0);
      check("loss_still_ok",     32'(lock_ok),   32'd1);
      tick(1);   // loss edge E
      check("loss_pulse",        32'(lost_lock),  32'd1);
      check("loss_relock_cnt",   32'(relock_cnt), exp_cnt);
      check("loss_sys_rst",      32'(sys_rst),    32'd1);
      check("loss_lock_ok",      32'(lock_ok),    32'd0);
      check("loss_pll_rst",      32'(pll_rst),    32'd1);
      pll_locked = 1'b1;
      tick(1);   // E+1
      check("loss_pulse_end",    32'(lost_lock),  32'd0);
      tick(2);   // E+3
      check("loss_repulse_e3",   32'(pll_rst),    32'd1);
      tick(1);   // E+4
      check("loss_repulse_e4",   32'(pll_rst),    32'd0);
      tick(12);  // E+16
      check("relock_sys_e16",    32'(sys_rst),    32'd1);
      tick(1);   // E+17
      check("relock_sys_e17",    32'(sys_rst),    32'd0);
      check("relock_ok_e17",     32'(lock_ok),    32'd1);
    end

    // Reset asserted mid-FILTER
    pll_locked = 1'b0;
    tick(3);   // loss edge E
    pll_locked = 1'b1;
    tick(8);   // E+8, FILTER since E+5
    check("midf_sys_rst", 32'(sys_rst),    32'd1);
    check("midf_pll_rst", 32'(pll_rst),    32'd0);
    check("midf_cnt",     32'(relock_cnt), 32'd3);
    rst = 1'b1;
    tick(1);
    check("midf_rst_pll_rst",    32'(pll_rst),    32'd1);
    check("midf_rst_sys_rst",    32'(sys_rst),    32'd1);
    check("midf_rst_lock_ok",    32'(lock_ok),    32'd0);
    check("midf_rst_lost_lock",  32'(lost_lock),  32'd0);
    check("midf_rst_relock_cnt", 32'(relock_cnt), 32'd0);
    rst = 1'b0;
    tick(3);
    check("midf_again_e3",  32'(pll_rst), 32'd1);
    tick(1);
    check("midf_again_e4",  32'(pll_rst), 32'd0);
    tick(12);
    check("midf_again_e16", 32'(sys_rst), 32'd1);
    tick(1);
    check("midf_again_e17", 32'(sys_rst), 32'd0);

    // Filter abort: lk_s high for 5 cycles, low 1, high again
    rst        = 1'b1;
    pll_locked = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);   // edge 4: WAITLOCK
    check("abort_pll_rst_e4", 32'(pll_rst), 32'd0);
    tick(2);   // edge 6
    pll_locked = 1'b1;
    tick(5);   // edge 11
    pll_locked = 1'b0;
    tick(1);   // edge 12
    pll_locked = 1'b1;
    tick(9);   // edge 21: would already be RUN without the abort
    check("abort_sys_e21",  32'(sys_rst), 32'd1);
    tick(5);   // edge 26
    check("abort_sys_e26",  32'(sys_rst), 32'd1);
    tick(1);   // edge 27 = 13 after lk_s rises again on edge 14
    check("abort_sys_e27",  32'(sys_rst), 32'd0);
    check("abort_ok_e27",   32'(lock_ok), 32'd1);

    // Lock never arrives
    rst        = 1'b1;
    pll_locked = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);   // edge 4
    check("nolock_pll_rst_e4", 32'(pll_rst), 32'd0);
`ifdef PLL_LOCK_TIMEOUT_EN
    tick(63);  // edge 67
    check("tmo_pll_rst_e67",  32'(pll_rst),    32'd0);
    tick(1);   // edge 68
    check("tmo_pll_rst_e68",  32'(pll_rst),    32'd1);
    check("tmo_relock_e68",   32'(relock_cnt), 32'd0);
    tick(4);   // edge 72
    check("tmo_pll_rst_e72",  32'(pll_rst),    32'd0);
    tick(63);  // edge 135
    check("tmo_pll_rst_e135", 32'(pll_rst),    32'd0);
    tick(1);   // edge 136
    check("tmo_pll_rst_e136", 32'(pll_rst),    32'd1);
    check("tmo_sys_rst_e136", 32'(sys_rst),    32'd1);
`else
    tick(100);
    check("nolock_pll_rst_e104", 32'(pll_rst),    32'd0);
    check("nolock_sys_rst_e104", 32'(sys_rst),    32'd1);
    check("nolock_relock_e104",  32'(relock_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
